// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - BCD mm:ss count-up stopwatch with target alarm, lap hold and blink
// Buttons pass through a sample flop and a history flop, so a press acts one cycle after it is sampled.
module stopwatch_controller #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        run_btn,
  input  logic        lap_btn,
  input  logic [15:0] target,
  output logic [3:0]  unit_sec,
  output logic [3:0]  tens_sec,
  output logic [3:0]  unit_min,
  output logic [3:0]  tens_min,
  output logic        running,
  output logic        lap_hold,
  output logic        alarm,
  output logic        led_blink
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     latch_q, latch_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic            lap_hold_q, lap_hold_d;
  logic            run_s_q, run_q, lap_s_q, lap_q;

  logic            run_edge, lap_edge, tick, overflow, match;
  logic [15:0]     count_inc;

  assign run_edge = run_s_q & ~run_q;
  assign lap_edge = lap_s_q & ~lap_q;
  assign tick     = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));

  // BCD ripple increment; overflow flags a carry out of tens_min.
  always_comb begin
    count_inc = count_q;
    overflow  = 1'b0;
    if (count_q[3:0] != 4'd9) begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end else begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] != 4'd5) begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end else begin
        count_inc[7:4] = 4'd0;
        if (count_q[11:8] != 4'd9) begin
          count_inc[11:8] = count_q[11:8] + 4'd1;
        end else begin
          count_inc[11:8] = 4'd0;
          if (count_q[15:12] != 4'd9) begin
            count_inc[15:12] = count_q[15:12] + 4'd1;
          end else begin
            overflow = 1'b1;
          end
        end
      end
    end
  end

  assign match = (target != 16'h0000) && (count_inc == target) && !overflow;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    latch_d     = latch_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    lap_hold_d  = lap_hold_q;

    case (state_q)
      S_IDLE: begin
        count_d = 16'h0000;
        presc_d = '0;
        if (run_edge) state_d = S_RUN;
      end
      S_RUN: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          // Saturate at 99:59 rather than wrapping to 00:00.
          if (overflow) begin
            state_d = S_DONE;
          end else begin
            count_d = count_inc;
            if (match) state_d = S_DONE;
          end
        end
        if (run_edge && state_d != S_DONE) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (run_edge) state_d = S_RUN;
      end
      S_DONE: begin
        presc_d = '0;
        if (run_edge) begin
          state_d = S_IDLE;
          count_d = 16'h0000;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_RUN || state_q == S_PAUSE) && lap_edge) begin
      lap_hold_d = !lap_hold_q;
      if (!lap_hold_q) latch_d = count_q;
    end
    if (state_d == S_IDLE || state_d == S_DONE) lap_hold_d = 1'b0;

    if (state_d == S_DONE) begin
      if (state_q != S_DONE) begin
        blink_d     = 1'b1;
        blink_cnt_d = '0;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_d     = !blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= 16'h0000;
      latch_q     <= 16'h0000;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      lap_hold_q  <= 1'b0;
      run_s_q     <= run_btn;
      run_q       <= run_btn;
      lap_s_q     <= lap_btn;
      lap_q       <= lap_btn;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      latch_q     <= latch_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      lap_hold_q  <= lap_hold_d;
      run_s_q     <= run_btn;
      run_q       <= run_s_q;
      lap_s_q     <= lap_btn;
      lap_q       <= lap_s_q;
    end
  end

  assign {tens_min, unit_min, tens_sec, unit_sec} = lap_hold_q ? latch_q : count_q;
  assign running   = (state_q == S_RUN);
  assign alarm     = (state_q == S_DONE);
  assign lap_hold  = lap_hold_q;
  assign led_blink = blink_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - directed checks of stopwatch_controller at small divider settings
module tb_stopwatch_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset4, run4, lap4;
  logic [15:0] target4;
  logic [3:0]  us4, ts4, um4, tm4;
  logic        running4, lap_hold4, alarm4, blink4;

  logic        reset1, run1, lap1;
  logic [15:0] target1;
  logic [3:0]  us1, ts1, um1, tm1;
  logic        running1, lap_hold1, alarm1, blink1;

  stopwatch_controller #(.TICK_DIV(4), .BLINK_DIV(3)) u_dut4 (
    .CLOCK_50(clk), .reset(reset4), .run_btn(run4), .lap_btn(lap4), .target(target4),
    .unit_sec(us4), .tens_sec(ts4), .unit_min(um4), .tens_min(tm4),
    .running(running4), .lap_hold(lap_hold4), .alarm(alarm4), .led_blink(blink4)
  );

  stopwatch_controller #(.TICK_DIV(1), .BLINK_DIV(3)) u_dut1 (
    .CLOCK_50(clk), .reset(reset1), .run_btn(run1), .lap_btn(lap1), .target(target1),
    .unit_sec(us1), .tens_sec(ts1), .unit_min(um1), .tens_min(tm1),
    .running(running1), .lap_hold(lap_hold1), .alarm(alarm1), .led_blink(blink1)
  );

  wire [15:0] disp4  = {tm4, um4, ts4, us4};
  wire [15:0] disp1  = {tm1, um1, ts1, us1};
  wire [3:0]  flags4 = {running4, lap_hold4, alarm4, blink4};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_run4();
    run4 = 1'b1; step(1); run4 = 1'b0; step(1);
  endtask

  task automatic press_lap4();
    lap4 = 1'b1; step(1); lap4 = 1'b0; step(1);
  endtask

  task automatic press_run1();
    run1 = 1'b1; step(1); run1 = 1'b0; step(1);
  endtask

  task automatic reset_dut4();
    reset4 = 1'b1; step(1); reset4 = 1'b0;
  endtask

  initial begin
    reset4 = 1'b1; run4 = 1'b0; lap4 = 1'b0; target4 = 16'h0000;
    reset1 = 1'b1; run1 = 1'b1; lap1 = 1'b0; target1 = 16'h0000;
    step(3);
    reset4 = 1'b0; reset1 = 1'b0;
    step(1);
    check("reset_disp", disp4, 16'h0000);
    check("reset_flags", flags4, 4'b0000);

    // run held through reset release must not start dut1
    step(5);
    check("held_run_no_start", running1, 1'b0);
    check("held_run_disp", disp1, 16'h0000);
    run1 = 1'b0;
    step(2);

    press_run4();
    check("run_entry", running4, 1'b1);
    check("run_entry_disp", disp4, 16'h0000);
    step(40);
    check("run40_disp", disp4, 16'h0010);
    check("run40_running", running4, 1'b1);
    press_run4();
    check("pause_running", running4, 1'b0);
    step(20);
    check("pause_frozen", disp4, 16'h0010);

    // pause/resume keeps the fractional second
    reset_dut4();
    press_run4();
    press_run4();
    check("frac_paused", running4, 1'b0);
    step(10);
    press_run4();
    check("frac_resumed", running4, 1'b1);
    step(1);
    check("frac_before_tick", disp4, 16'h0000);
    step(1);
    check("frac_first_tick", disp4, 16'h0001);

    // target alarm and blink
    reset_dut4();
    target4 = 16'h0003;
    press_run4();
    step(11);
    check("tgt_before", disp4, 16'h0002);
    check("tgt_before_alarm", alarm4, 1'b0);
    step(1);
    check("tgt_disp", disp4, 16'h0003);
    check("tgt_flags", flags4, 4'b0011);
    step(2);
    check("blink_hold", blink4, 1'b1);
    step(1);
    check("blink_toggle0", blink4, 1'b0);
    step(3);
    check("blink_toggle1", blink4, 1'b1);
    press_run4();
    check("done_to_idle_disp", disp4, 16'h0000);
    check("done_to_idle_flags", flags4, 4'b0000);

    // reset while blinking in DONE
    press_run4();
    step(12);
    check("redone_alarm", alarm4, 1'b1);
    step(1);
    reset4 = 1'b1;
    step(1);
    check("reset_done_flags", flags4, 4'b0000);
    check("reset_done_disp", disp4, 16'h0000);
    reset4 = 1'b0;
    target4 = 16'h0000;
    step(1);

    // lap hold
    press_run4();
    step(20);
    check("lap_pre", disp4, 16'h0005);
    press_lap4();
    check("lap_set", lap_hold4, 1'b1);
    check("lap_latch", disp4, 16'h0005);
    step(10);
    check("lap_frozen", disp4, 16'h0005);
    press_lap4();
    check("lap_clear", lap_hold4, 1'b0);
    check("lap_live", disp4, 16'h0008);
    reset_dut4();
    press_lap4();
    check("lap_idle", lap_hold4, 1'b0);

    // carry chain and saturation at TICK_DIV=1
    press_run1();
    step(59);
    check("carry_0059", disp1, 16'h0059);
    step(1);
    check("carry_0100", disp1, 16'h0100);
    step(539);
    check("carry_0959", disp1, 16'h0959);
    step(1);
    check("carry_1000", disp1, 16'h1000);
    step(5399);
    check("sat_9959", disp1, 16'h9959);
    check("sat_running", running1, 1'b1);
    step(1);
    check("sat_done_disp", disp1, 16'h9959);
    check("sat_done_alarm", alarm1, 1'b1);
    check("sat_done_running", running1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Count-up companion to the countdown timer controller: where the timer loads mm:ss from switches and counts toward 00:00, this block starts at 00:00 and counts upward in BCD mm:ss. It stops and raises an alarm when the count reaches a switch-selected target, or when it saturates at 99:59. It sits in the DE-board top level with CLOCK_50, takes inverted KEY levels as run and lap buttons, and drives four dec2_7seg digit decoders plus a LEDR blink enable.

## Interface
- TICK_DIV, 50000000: CLOCK_50 cycles per counted second.
- BLINK_DIV, 25000000: CLOCK_50 cycles per led_blink toggle in DONE.
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- run_btn  in  1  active-high level, already synchronized. A rising edge is a start/stop request.
- lap_btn  in  1  active-high level, already synchronized. A rising edge is a lap-hold toggle.
- target  in  16  BCD {tens_min, unit_min, tens_sec, unit_sec}. 16'h0000 disables the alarm.
- unit_sec, tens_sec, unit_min, tens_min  out  4 each  displayed BCD digits.
- running  out  1  high in RUN.
- lap_hold  out  1  high while the display is frozen.
- alarm  out  1  high in DONE.
- led_blink  out  1  blinking LED enable.

## Operation
- Edge detect: edge = btn & ~btn_q per button. During reset, btn_q loads btn, so a button held through reset release produces no edge.
- Count register: four BCD digits.
  - unit_sec wraps 9→0 with carry; tens_sec wraps 5→0 with carry.
  - unit_min wraps 9→0 with carry; tens_min 9 with carry-in is overflow.
- Prescaler: 0..TICK_DIV-1.
  - Increments only in RUN; held in PAUSE, so the fractional second is preserved.
  - Cleared in IDLE and DONE.
  - tick = RUN && prescaler == TICK_DIV-1; prescaler returns to 0 at the tick.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: count 00:00. run edge → RUN.
  - RUN: tick increments the count.
    - run edge → PAUSE. If a tick occurs in the same cycle, the increment still applies.
    - If tick and (target != 0 and next count == target) → DONE, with count = target.
    - If tick and overflow → DONE, with count held at 99:59 (saturate, no wrap).
    - DONE takes priority over PAUSE when both occur in the same cycle.
  - PAUSE: run edge → RUN. Count frozen.
  - DONE: count frozen, alarm=1. run edge → IDLE with count cleared. lap edges ignored.
- Target comparison runs only on the tick-produced next count.
  - A target already passed, or a non-BCD/invalid target (e.g. seconds > 59), never matches; the count runs to 99:59 saturation.
- Lap:
  - A lap edge in RUN or PAUSE toggles lap_hold.
  - Setting lap_hold snapshots the current count into a display latch.
  - Outputs show the latch while lap_hold=1 and the live count otherwise.
  - Counting continues underneath.
  - lap_hold is forced 0 on entry to IDLE and to DONE, so the final value is shown.
- Blink:
  - On entry to DONE, led_blink=1 and the blink counter is 0.
  - The counter runs 0..BLINK_DIV-1; led_blink toggles at wrap.
  - Outside DONE, led_blink=0.

## Timing
- Reset values: state IDLE, all digits 0, prescaler 0, running 0, lap_hold 0, alarm 0, led_blink 0, blink counter 0.
- All outputs are registered or decoded from registers. A change caused by an input edge sampled at edge N is visible after edge N+1, because btn_q adds one cycle.
- From RUN entry at 00:00, the first increment occurs TICK_DIV cycles later; subsequent increments every TICK_DIV cycles of RUN time.
- Pause/resume loses no cycles: total RUN cycles / TICK_DIV = seconds counted.
- DONE entry is on the same edge as the matching increment, so alarm rises on the cycle the target digits first appear.
- reset mid-operation, in any state, returns everything to reset values on the next edge; it overrides same-cycle edges and ticks.

## Test plan
- TICK_DIV=4, target=0: reset, run edge, hold RUN 40 cycles → count 00:10, running=1. Run edge → running=0; count stays 00:10 over 20 cycles.
- TICK_DIV=4, target=16'h0003: run → exactly 12 RUN cycles later count 00:03, alarm=1, running=0. Then BLINK_DIV=3: led_blink toggles every 3 cycles. Run edge → IDLE, 00:00, alarm=0.
- Carry chain: preload path by running from 00:00 with TICK_DIV=1 and target=0.
  - 59→1:00 at tick 60; 9:59→10:00 at tick 600.
  - Reaches 99:59 at tick 5999, then DONE at tick 6000 with display still 99:59.
- TICK_DIV=4: pause after 2 RUN cycles, idle 10 cycles, resume → first increment after 2 more RUN cycles.
- Lap: running at 00:05, lap edge → display frozen at 00:05 while the internal count reaches 00:08. Second lap edge → display 00:08. Lap edge in IDLE → lap_hold stays 0.
- Hold run_btn high across reset release → no RUN entry. Assert reset while in DONE with blinking → all outputs 0 next cycle.
